// File: rtl/scratchpad_pkg.sv
// Shared types for the scratchpad bus port: FSM state encodings, the
// writeback FIFO entry layout and the bytes-per-beat helper.
// Ports: none (package).
package scratchpad_pkg;

  // Width of the shared address/data bus. The FIFO entry layout follows it.
  localparam int SPM_DATA_W = 32;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_ADDR,
    TX_DATA
  } tx_state_t;

  typedef enum logic {
    RX_ADDR,
    RX_DATA
  } rx_state_t;

  typedef struct packed {
    logic [SPM_DATA_W-1:0] addr;
    logic [SPM_DATA_W-1:0] data;
  } wb_entry_t;

  // Byte stride between consecutive beats on a bus of the given width.
  function automatic int spm_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/scratchpad_wb_fifo.sv
// Writeback FIFO: DEPTH entries of {addr,data}, head read plus head+1 address peek.
// Latency: a push is visible at head / in count the cycle after it is accepted.
// Backpressure: ready = (count < DEPTH), with no look-ahead to a same-cycle pop.
// Ports: clk, rst_n | push, push_entry, ready | pop | head, next_addr, count
module scratchpad_wb_fifo
  import scratchpad_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  output logic                         ready,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic [SPM_DATA_W-1:0]        next_addr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign ready     = (count < CW'(DEPTH));
  assign do_push   = push && ready;
  assign do_pop    = pop && (count != '0);
  assign head      = mem[rd_ptr];
  // Pointer width is log2(DEPTH), so the +1 wraps modulo DEPTH for free.
  assign next_addr = mem[rd_ptr + PW'(1)].addr;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scratchpad_bus_port.sv
// Scratchpad-side endpoint of the arbiter link: queues local writebacks and sends
// them as coalesced address-then-data bursts; turns inbound bursts into scratchpad writes.
// Latency: outbound address beat one cycle after grant; inbound write one cycle after its beat.
// Backpressure: wb_ready drops when the FIFO is full; inbound side never stalls.
// Ports: CLK, nRST | wb_valid/wb_ready/wb_addr/wb_data/wb_count |
//        req_out/dbus_out/last_out/bus_ready/bus_own_ack | req_in/dbus_in/last_in |
//        spm_wen/spm_waddr/spm_wdata | err_proto
module scratchpad_bus_port
  import scratchpad_pkg::*;
#(
  parameter int DATA_W    = SPM_DATA_W,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [DATA_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  output logic [$clog2(DEPTH+1)-1:0] wb_count,
  output logic                       req_out,
  output logic [DATA_W-1:0]          dbus_out,
  output logic                       last_out,
  input  logic                       bus_ready,
  input  logic                       bus_own_ack,
  input  logic                       req_in,
  input  logic [DATA_W-1:0]          dbus_in,
  input  logic                       last_in,
  output logic                       spm_wen,
  output logic [DATA_W-1:0]          spm_waddr,
  output logic [DATA_W-1:0]          spm_wdata,
  output logic                       err_proto
);

  localparam int BYTES = spm_bytes(DATA_W);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BW    = $clog2(MAX_BURST + 1);

  // ---------------- writeback FIFO ----------------
  wb_entry_t         head;
  logic [DATA_W-1:0] next_addr;
  logic              fifo_pop;

  scratchpad_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (CLK),
    .rst_n      (nRST),
    .push       (wb_valid),
    .push_entry ('{addr: wb_addr, data: wb_data}),
    .ready      (wb_ready),
    .pop        (fifo_pop),
    .head       (head),
    .next_addr  (next_addr),
    .count      (wb_count)
  );

  // ---------------- outbound FSM ----------------
  tx_state_t         tx_state, tx_state_nxt;
  logic [DATA_W-1:0] tx_addr;
  logic [BW-1:0]     tx_beat;
  logic              burst_more;

  // The entry behind the head must already be queued, sit exactly one beat
  // above the current address (wrapping through zero is fine), and the burst
  // must still have room.
  assign burst_more = (wb_count >= CW'(2))
                   && (next_addr == tx_addr + DATA_W'(BYTES))
                   && ((int'(tx_beat) + 1) < MAX_BURST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    fifo_pop     = 1'b0;
    req_out      = 1'b0;
    dbus_out     = '0;
    last_out     = 1'b0;
    case (tx_state)
      TX_IDLE: if (wb_count != '0) tx_state_nxt = TX_REQ;
      TX_REQ: begin
        req_out = bus_ready;
        if (bus_own_ack) tx_state_nxt = TX_ADDR;
      end
      TX_ADDR: begin
        dbus_out     = head.addr;
        tx_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        dbus_out = head.data;
        fifo_pop = 1'b1;
        if (!burst_more) begin
          last_out     = 1'b1;
          // Anything still queued after this pop needs a fresh request.
          tx_state_nxt = (wb_count >= CW'(2)) ? TX_REQ : TX_IDLE;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tx_addr <= '0;
      tx_beat <= '0;
    end else if (tx_state == TX_ADDR) begin
      tx_addr <= head.addr;
      tx_beat <= '0;
    end else if ((tx_state == TX_DATA) && burst_more) begin
      tx_addr <= tx_addr + DATA_W'(BYTES);
      tx_beat <= tx_beat + BW'(1);
    end
  end

  // ---------------- inbound FSM ----------------
  rx_state_t         rx_state, rx_state_nxt;
  logic [DATA_W-1:0] rx_addr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) rx_state <= RX_ADDR;
    else       rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    if (req_in) begin
      case (rx_state)
        // An address beat flagged last is malformed and leaves us here.
        RX_ADDR: if (!last_in) rx_state_nxt = RX_DATA;
        RX_DATA: if (last_in)  rx_state_nxt = RX_ADDR;
        default: rx_state_nxt = RX_ADDR;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rx_addr   <= '0;
      spm_wen   <= 1'b0;
      spm_waddr <= '0;
      spm_wdata <= '0;
      err_proto <= 1'b0;
    end else begin
      spm_wen   <= 1'b0;
      err_proto <= 1'b0;
      if (req_in) begin
        if (rx_state == RX_ADDR) begin
          if (last_in) err_proto <= 1'b1;
          else         rx_addr   <= dbus_in;
        end else begin
          spm_wen   <= 1'b1;
          spm_waddr <= rx_addr;
          spm_wdata <= dbus_in;
          rx_addr   <= rx_addr + DATA_W'(BYTES);
        end
      end
    end
  end

endmodule

// File: tb/tb_scratchpad_bus_port.sv
// Self-checking bench for scratchpad_bus_port: reset state, table-driven inbound
// vectors, directed outbound sequences, and a randomized run against a queue model.
module tb_scratchpad_bus_port;

  localparam int DEPTH = 8;
  localparam int MAXB  = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [31:0] wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [3:0]  wb_count;
  logic        req_out;
  logic [31:0] dbus_out;
  logic        last_out;
  logic        bus_ready = 1'b0;
  logic        bus_own_ack = 1'b0;
  logic        req_in = 1'b0;
  logic [31:0] dbus_in = '0;
  logic        last_in = 1'b0;
  logic        spm_wen;
  logic [31:0] spm_waddr;
  logic [31:0] spm_wdata;
  logic        err_proto;

  int checks = 0;
  int errors = 0;

  scratchpad_bus_port dut (
    .CLK(CLK), .nRST(nRST),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_count(wb_count),
    .req_out(req_out), .dbus_out(dbus_out), .last_out(last_out),
    .bus_ready(bus_ready), .bus_own_ack(bus_own_ack),
    .req_in(req_in), .dbus_in(dbus_in), .last_in(last_in),
    .spm_wen(spm_wen), .spm_waddr(spm_waddr), .spm_wdata(spm_wdata),
    .err_proto(err_proto)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // All stimulus changes land 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    next_cycle();
    wb_valid = 1'b0;
  endtask

  // Wait for a request, grant it one cycle later, then expect an address beat
  // followed by n data beats d0, d0+1, ... with last_out on the final one.
  task automatic get_burst(input string nm, input logic [31:0] a,
                           input logic [31:0] d0, input int n);
    int w = 0;
    #2;
    while (!req_out && w < 20) begin
      next_cycle();
      #2;
      w++;
    end
    chk({nm, " req_out"}, {31'b0, req_out}, 32'd1);
    next_cycle();
    bus_own_ack = 1'b1;
    next_cycle();
    bus_own_ack = 1'b0;
    #2;
    chk({nm, " addr beat"}, dbus_out, a);
    chk({nm, " addr last"}, {31'b0, last_out}, 32'd0);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      #2;
      chk($sformatf("%s data%0d", nm, i), dbus_out, d0 + 32'(i));
      chk($sformatf("%s last%0d", nm, i), {31'b0, last_out}, {31'b0, (i == n - 1)});
    end
    next_cycle();
  endtask

  typedef struct {
    logic        rq;
    logic        lst;
    logic [31:0] d;
    logic        wen;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        err;
  } rxv_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  initial begin
    rxv_t rxv[13];
    ent_t q[$];

    // ---------------- reset state ----------------
    #3;
    chk("rst wb_ready", {31'b0, wb_ready}, 32'd1);
    chk("rst wb_count", {28'b0, wb_count}, 32'd0);
    chk("rst req_out", {31'b0, req_out}, 32'd0);
    chk("rst dbus_out", dbus_out, 32'd0);
    chk("rst last_out", {31'b0, last_out}, 32'd0);
    chk("rst spm_wen", {31'b0, spm_wen}, 32'd0);
    chk("rst spm_waddr", spm_waddr, 32'd0);
    chk("rst spm_wdata", spm_wdata, 32'd0);
    chk("rst err_proto", {31'b0, err_proto}, 32'd0);
    next_cycle();
    nRST = 1'b1;
    next_cycle();

    // ---------------- inbound vectors ----------------
    // Each row: inputs for one cycle, registered outputs expected after the edge.
    rxv[0]  = '{1, 0, 32'h40,       0, 0,           0,  0};
    rxv[1]  = '{1, 0, 32'hA,        1, 32'h40,      32'hA, 0};
    rxv[2]  = '{1, 1, 32'hB,        1, 32'h44,      32'hB, 0};
    rxv[3]  = '{0, 0, 32'h0,        0, 0,           0,  0};
    rxv[4]  = '{1, 1, 32'h80,       0, 0,           0,  1};
    rxv[5]  = '{0, 0, 32'h0,        0, 0,           0,  0};
    rxv[6]  = '{1, 0, 32'h90,       0, 0,           0,  0};
    rxv[7]  = '{0, 0, 32'h0,        0, 0,           0,  0};
    rxv[8]  = '{1, 1, 32'h5,        1, 32'h90,      32'h5, 0};
    rxv[9]  = '{1, 0, 32'hFFFFFFFC, 0, 0,           0,  0};
    rxv[10] = '{1, 0, 32'h1,        1, 32'hFFFFFFFC, 32'h1, 0};
    rxv[11] = '{1, 1, 32'h2,        1, 32'h0,       32'h2, 0};
    rxv[12] = '{0, 0, 32'h0,        0, 0,           0,  0};
    for (int i = 0; i < 13; i++) begin
      req_in  = rxv[i].rq;
      last_in = rxv[i].lst;
      dbus_in = rxv[i].d;
      next_cycle();
      chk($sformatf("rx%0d spm_wen", i), {31'b0, spm_wen}, {31'b0, rxv[i].wen});
      chk($sformatf("rx%0d err_proto", i), {31'b0, err_proto}, {31'b0, rxv[i].err});
      if (rxv[i].wen) begin
        chk($sformatf("rx%0d spm_waddr", i), spm_waddr, rxv[i].wa);
        chk($sformatf("rx%0d spm_wdata", i), spm_wdata, rxv[i].wd);
      end
    end
    req_in = 1'b0; last_in = 1'b0;

    // ---------------- single writeback ----------------
    bus_ready = 1'b1;
    push(32'h100, 32'hDEADBEEF);
    #2;
    chk("single count", {28'b0, wb_count}, 32'd1);
    chk("single idle req", {31'b0, req_out}, 32'd0);
    next_cycle();
    get_burst("single", 32'h100, 32'hDEADBEEF, 1);
    #2;
    chk("single count end", {28'b0, wb_count}, 32'd0);
    next_cycle();

    // ---------------- coalescing ----------------
    for (int i = 0; i < 5; i++) push(32'h200 + 32'(4 * i), 32'(i + 1));
    get_burst("coal1", 32'h200, 32'd1, 4);
    get_burst("coal2", 32'h210, 32'd5, 1);
    #2;
    chk("coal count end", {28'b0, wb_count}, 32'd0);
    next_cycle();

    // ---------------- non-contiguous ----------------
    push(32'h300, 32'h11);
    push(32'h400, 32'h22);
    get_burst("ncont1", 32'h300, 32'h11, 1);
    get_burst("ncont2", 32'h400, 32'h22, 1);

    // ---------------- FIFO full ----------------
    bus_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(32'h500 + 32'(16 * i), 32'h50 + 32'(i));
    #2;
    chk("full wb_ready", {31'b0, wb_ready}, 32'd0);
    chk("full wb_count", {28'b0, wb_count}, 32'd8);
    chk("full req gated", {31'b0, req_out}, 32'd0);
    next_cycle();
    push(32'h5F0, 32'h99);
    #2;
    chk("full 9th dropped", {28'b0, wb_count}, 32'd8);
    next_cycle();
    bus_ready = 1'b1;
    get_burst("full0", 32'h500, 32'h50, 1);
    #2;
    chk("full ready again", {31'b0, wb_ready}, 32'd1);
    chk("full count 7", {28'b0, wb_count}, 32'd7);
    next_cycle();
    for (int i = 1; i < DEPTH; i++)
      get_burst($sformatf("full%0d", i), 32'h500 + 32'(16 * i), 32'h50 + 32'(i), 1);
    #2;
    chk("full drained", {28'b0, wb_count}, 32'd0);
    next_cycle();

    // ---------------- reset mid-burst ----------------
    push(32'h600, 32'h61);
    push(32'h604, 32'h62);
    push(32'h608, 32'h63);
    #2;
    chk("mid req", {31'b0, req_out}, 32'd1);
    next_cycle();
    bus_own_ack = 1'b1;
    req_in = 1'b1; last_in = 1'b0; dbus_in = 32'h1000;
    next_cycle();
    bus_own_ack = 1'b0;
    dbus_in = 32'h55;
    #2;
    chk("mid addr", dbus_out, 32'h600);
    next_cycle();
    dbus_in = 32'h56; last_in = 1'b1;
    #2;
    chk("mid beat0", dbus_out, 32'h61);
    next_cycle();
    req_in = 1'b0; last_in = 1'b0;
    #2;
    chk("mid beat1", dbus_out, 32'h62);
    chk("mid spm_wen pre", {31'b0, spm_wen}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("mid rst req_out", {31'b0, req_out}, 32'd0);
    chk("mid rst dbus_out", dbus_out, 32'd0);
    chk("mid rst last_out", {31'b0, last_out}, 32'd0);
    chk("mid rst spm_wen", {31'b0, spm_wen}, 32'd0);
    chk("mid rst wb_count", {28'b0, wb_count}, 32'd0);
    chk("mid rst wb_ready", {31'b0, wb_ready}, 32'd1);
    next_cycle();
    nRST = 1'b1;
    next_cycle();
    push(32'h700, 32'h77);
    get_burst("post rst", 32'h700, 32'h77, 1);
    #2;
    chk("post rst count", {28'b0, wb_count}, 32'd0);
    next_cycle();

    // ---------------- randomized run ----------------
    begin : rnd
      int          phase;
      int          phase_n;
      int          beat;
      int          wait_cnt;
      logic [31:0] cur;
      logic [31:0] last_a;
      logic [31:0] na;
      logic        do_push;
      logic        do_pop;
      logic        last_exp;
      logic        exp_wen;
      logic        exp_err;
      logic [31:0] exp_wa;
      logic [31:0] exp_wd;
      logic        in_burst;
      logic [31:0] rx_a;
      phase = 0; beat = 0; wait_cnt = 0; cur = '0; last_a = 32'h1000;
      exp_wen = 1'b0; exp_err = 1'b0; exp_wa = '0; exp_wd = '0;
      in_burst = 1'b0; rx_a = '0;
      for (int c = 0; c < 3000; c++) begin
        // drive
        wb_valid = ($urandom % 2) == 1;
        if (($urandom % 4) != 0)      na = last_a + 32'd4;
        else if (($urandom % 6) == 0) na = 32'hFFFF_FFF8;
        else                          na = $urandom & 32'hFFFF_FFFC;
        wb_addr     = na;
        wb_data     = $urandom;
        bus_ready   = ($urandom % 4) != 0;
        bus_own_ack = 1'b0;
        req_in      = ($urandom % 5) < 3;
        last_in     = ($urandom % 3) == 0;
        dbus_in     = $urandom;
        #2;

        // inbound: writes expected from the previous cycle's beat
        chk("rnd spm_wen", {31'b0, spm_wen}, {31'b0, exp_wen});
        chk("rnd err_proto", {31'b0, err_proto}, {31'b0, exp_err});
        if (exp_wen) begin
          chk("rnd spm_waddr", spm_waddr, exp_wa);
          chk("rnd spm_wdata", spm_wdata, exp_wd);
        end
        exp_wen = 1'b0;
        exp_err = 1'b0;
        if (req_in) begin
          if (!in_burst) begin
            if (last_in) exp_err = 1'b1;
            else begin rx_a = dbus_in; in_burst = 1'b1; end
          end else begin
            exp_wen = 1'b1; exp_wa = rx_a; exp_wd = dbus_in;
            rx_a = rx_a + 32'd4;
            if (last_in) in_burst = 1'b0;
          end
        end

        // outbound
        chk("rnd wb_count", {28'b0, wb_count}, 32'(q.size()));
        chk("rnd wb_ready", {31'b0, wb_ready}, {31'b0, q.size() < DEPTH});
        do_push = wb_valid && (q.size() < DEPTH);
        do_pop  = 1'b0;
        phase_n = phase;
        if (phase != 0 && q.size() == 0) begin
          chk("rnd burst nonempty", 32'(q.size()), 32'd1);
          phase_n = 0;
        end else if (phase == 0) begin
          chk("rnd idle dbus", dbus_out, 32'd0);
          chk("rnd idle last", {31'b0, last_out}, 32'd0);
          chk("rnd req gated", {31'b0, req_out && !bus_ready}, 32'd0);
          if (req_out) chk("rnd req nonempty", {31'b0, q.size() != 0}, 32'd1);
          wait_cnt = (q.size() != 0) ? wait_cnt + 1 : 0;
          chk("rnd grant wait", {31'b0, wait_cnt < 300}, 32'd1);
          if (req_out && ($urandom % 2) == 1) begin
            bus_own_ack = 1'b1;
            phase_n     = 1;
            wait_cnt    = 0;
          end
        end else if (phase == 1) begin
          chk("rnd addr beat", dbus_out, q[0].a);
          chk("rnd addr last", {31'b0, last_out}, 32'd0);
          chk("rnd addr req", {31'b0, req_out}, 32'd0);
          cur = q[0].a; beat = 0; phase_n = 2;
        end else begin
          chk("rnd data beat", dbus_out, q[0].d);
          last_exp = !((beat + 1 < MAXB) && (q.size() >= 2) && (q[1].a == cur + 32'd4));
          chk("rnd data last", {31'b0, last_out}, {31'b0, last_exp});
          chk("rnd data req", {31'b0, req_out}, 32'd0);
          do_pop = 1'b1;
          if (last_exp) phase_n = 0;
          else begin beat++; cur = cur + 32'd4; end
        end

        next_cycle();
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          q.push_back('{a: na, d: wb_data});
          last_a = na;
        end
        phase = phase_n;
      end
    end

    wb_valid = 1'b0; req_in = 1'b0; bus_own_ack = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scratchpad_bus_port.md
Name: scratchpad_bus_port

Overview:
- Scratchpad-side endpoint of the MMMU arbiter link; second generation of the scratchpad controller bus port.
- Buffers local scratchpad writebacks in a DEPTH-entry FIFO and sends them as address-then-data bursts.
- Coalesces address-contiguous entries into bursts of up to MAX_BURST beats, marked by a last flag.
- Receives inbound address/data bursts from the arbiter (off-chip programming) and drives the scratchpad write port.

Parameters:
- DATA_W, 32, width of the data bus and of addresses. Addresses travel on the same bus, so both are DATA_W wide.
- DEPTH, 8, writeback FIFO entries. Must be a power of two, 2 or more.
- MAX_BURST, 4, maximum number of data beats per outbound burst, 1 or more.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- wb_valid  in  1  local writeback enqueue strobe
- wb_ready  out  1  FIFO can accept an entry
- wb_addr  in  DATA_W  writeback byte address
- wb_data  in  DATA_W  writeback data
- wb_count  out  $clog2(DEPTH+1)  current FIFO occupancy
- req_out  out  1  request for bus ownership (always a write)
- dbus_out  out  DATA_W  outbound address/data beat
- last_out  out  1  final data beat of the outbound burst
- bus_ready  in  1  arbiter permits a request
- bus_own_ack  in  1  arbiter grants the bus; start sending
- req_in  in  1  valid inbound beat
- dbus_in  in  DATA_W  inbound address/data beat
- last_in  in  1  final inbound data beat
- spm_wen  out  1  scratchpad write enable
- spm_waddr  out  DATA_W  scratchpad write address
- spm_wdata  out  DATA_W  scratchpad write data
- err_proto  out  1  one-cycle pulse on an inbound protocol violation

Behaviour:
- Reset (nRST low, takes effect immediately): all outputs 0 except wb_ready=1; FIFO emptied; both FSMs return to idle. A burst in flight is abandoned; no partial-burst recovery.
- BYTES = DATA_W/8.
- FIFO push:
  - Push occurs when wb_valid && wb_ready.
  - wb_ready = (wb_count < DEPTH). It does not look ahead to a pop in the same cycle.
  - A simultaneous push and pop leaves wb_count unchanged.
  - Pointers wrap modulo DEPTH.
- Outbound FSM has four states: TX_IDLE, TX_REQ, TX_ADDR, TX_DATA.
  - TX_IDLE -> TX_REQ when wb_count != 0.
  - TX_REQ: req_out = bus_ready (combinational). bus_own_ack -> TX_ADDR next cycle. bus_own_ack is ignored in every other state.
  - TX_ADDR, one cycle: dbus_out = head.addr; latch tx_addr = head.addr; beat count = 0; -> TX_DATA.
  - TX_DATA, one beat per cycle: dbus_out = head.data; pop head; beat count increments.
    - continue = (wb_count >= 2) && (entry[rd+1].addr == tx_addr + BYTES) && (beat count + 1 < MAX_BURST).
    - If continue: stay in TX_DATA and tx_addr += BYTES.
    - Otherwise: last_out = 1; next state is TX_REQ if wb_count >= 2, else TX_IDLE.
  - Address arithmetic is modulo 2^DATA_W. A wrap to 0 counts as contiguous.
  - An entry pushed in the same cycle is not visible to the continue check.
  - dbus_out = 0 and last_out = 0 outside TX_ADDR/TX_DATA.
- Inbound FSM has two states: RX_ADDR, RX_DATA.
  - RX_ADDR, req_in: capture rx_addr = dbus_in; -> RX_DATA.
  - RX_ADDR, req_in && last_in: err_proto pulses; beat is dropped; FSM stays in RX_ADDR.
  - RX_DATA, req_in: the next cycle drives spm_wen=1, spm_waddr=rx_addr, spm_wdata=dbus_in (registered, one-cycle latency); rx_addr += BYTES.
  - RX_DATA, req_in && last_in: -> RX_ADDR after the write.
  - Inbound accepts one beat per cycle with no backpressure.
  - Cycles without req_in produce no write and no state change.
- Inbound and outbound run fully independently and concurrently.
- Local writebacks never write the scratchpad through this block.

Decomposition:
- Package scratchpad_pkg holds:
  - tx_state_t {TX_IDLE, TX_REQ, TX_ADDR, TX_DATA}
  - rx_state_t {RX_ADDR, RX_DATA}
  - a typedef for the {addr,data} FIFO entry
  - a localparam helper for BYTES
- One sub-module: scratchpad_wb_fifo, a DEPTH-entry FIFO exposing head and head+1 peek, push/pop, and count.

Test Plan:
- Single writeback: push {0x100, 0xDEADBEEF}, bus_ready=1, ack one cycle after req_out -> dbus_out reads 0x100 then 0xDEADBEEF; last_out=1 on the data beat; wb_count ends at 0.
- Coalescing: push addresses 0x200, 0x204, 0x208, 0x20C, 0x210 (data 1..5) -> first burst is addr 0x200 with data 1,2,3,4 and last_out on the beat carrying data 4; a second burst follows with addr 0x210, data 5.
- Non-contiguous entries: push 0x300, then 0x400 -> two separate bursts, each with one data beat.
- FIFO full: push 8 entries with bus_ready=0 -> wb_ready=0 and wb_count=8. A 9th push is not accepted. After a grant, wb_ready=1 again.
- Inbound burst: req_in beats 0x40, 0xA, 0xB(last_in) -> spm writes (0x40, 0xA), then (0x44, 0xB), each one cycle after its beat; FSM back in RX_ADDR. Repeat with last_in on the address beat -> err_proto pulses and no write occurs.
- Reset mid-burst: deassert nRST during TX_DATA -> req_out, dbus_out, last_out and spm_wen go to 0 immediately; wb_count=0; a new push after reset is sent normally.
